// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle for instr_queue.
// master = fetch + decode side (drives requests), slave = the queue itself.
interface instr_queue_if #(
  parameter int DEPTH       = 4,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 1,
  parameter int ISA_SIZE    = 32,
  parameter int ADDR_SIZE   = 64
);
  logic                                  flush_i;
  logic                                  fetch_valid_i;
  logic                                  fetch_ready_o;
  logic [$clog2(FETCH_WIDTH+1)-1:0]      fetch_cnt_i;
  logic [FETCH_WIDTH*ISA_SIZE-1:0]       fetch_instr_i;
  logic [ADDR_SIZE-1:0]                  fetch_pc_i;
  logic [ISSUE_WIDTH-1:0]                issue_valid_o;
  logic [ISSUE_WIDTH*ISA_SIZE-1:0]       issue_instr_o;
  logic [ISSUE_WIDTH*ADDR_SIZE-1:0]      issue_pc_o;
  logic [$clog2(ISSUE_WIDTH+1)-1:0]      issue_take_i;
  logic [$clog2(DEPTH+1)-1:0]            count_o;

  modport master (
    output flush_i, fetch_valid_i, fetch_cnt_i, fetch_instr_i, fetch_pc_i, issue_take_i,
    input  fetch_ready_o, issue_valid_o, issue_instr_o, issue_pc_o, count_o
  );

  modport slave (
    input  flush_i, fetch_valid_i, fetch_cnt_i, fetch_instr_i, fetch_pc_i, issue_take_i,
    output fetch_ready_o, issue_valid_o, issue_instr_o, issue_pc_o, count_o
  );
endinterface

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode: multi-push, multi-pop, flush.
// Optional same-cycle bypass of an empty queue is enabled by defining IQUEUE_BYPASS_EN.
module instr_queue #(
  parameter int DEPTH       = 4,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 1,
  parameter int ISA_SIZE    = 32,
  parameter int ADDR_SIZE   = 64
) (
  input logic          clk_i,
  input logic          rstn_i,
  instr_queue_if.slave bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int FCW = $clog2(FETCH_WIDTH+1);

  logic [ISA_SIZE-1:0]  mem_instr [DEPTH];
  logic [ADDR_SIZE-1:0] mem_pc    [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          ready;
  logic          push_ok;
  logic          bypass;
  logic [CW-1:0] push_n;
  logic [CW-1:0] avail;
  logic [CW-1:0] lim;
  logic [CW-1:0] pop_n;
  logic [CW-1:0] skip_n;

  // Ready depends only on registered occupancy, so a same-cycle pop never raises it.
  always_comb begin
    ready   = (count <= CW'(DEPTH - FETCH_WIDTH));
    push_ok = bus.fetch_valid_i && ready && !bus.flush_i;
    push_n  = '0;
    if (push_ok) begin
      push_n = (bus.fetch_cnt_i > FCW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : CW'(bus.fetch_cnt_i);
    end
`ifdef IQUEUE_BYPASS_EN
    bypass = push_ok && (count == '0);
    avail  = bypass ? push_n : count;
`else
    bypass = 1'b0;
    avail  = count;
`endif
    lim    = (avail > CW'(ISSUE_WIDTH)) ? CW'(ISSUE_WIDTH) : avail;
    pop_n  = (CW'(bus.issue_take_i) > lim) ? lim : CW'(bus.issue_take_i);
    skip_n = bypass ? pop_n : '0;
  end

`ifdef IQUEUE_BYPASS_EN
  localparam int MW  = (FETCH_WIDTH > ISSUE_WIDTH) ? FETCH_WIDTH : ISSUE_WIDTH;
  localparam int FPW = MW * ISA_SIZE;
  logic [FPW-1:0] fetch_pad;
  assign fetch_pad = FPW'(bus.fetch_instr_i);
`endif

  always_comb begin
    bus.issue_valid_o = '0;
    bus.issue_instr_o = '0;
    bus.issue_pc_o    = '0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      bus.issue_valid_o[j]                          = (CW'(j) < avail);
      bus.issue_instr_o[j*ISA_SIZE +: ISA_SIZE]     = mem_instr[rd_ptr + PW'(j)];
      bus.issue_pc_o[j*ADDR_SIZE +: ADDR_SIZE]      = mem_pc[rd_ptr + PW'(j)];
`ifdef IQUEUE_BYPASS_EN
      if (bypass) begin
        bus.issue_instr_o[j*ISA_SIZE +: ISA_SIZE]   = fetch_pad[j*ISA_SIZE +: ISA_SIZE];
        bus.issue_pc_o[j*ADDR_SIZE +: ADDR_SIZE]    = bus.fetch_pc_i + ADDR_SIZE'(4*j);
      end
`endif
    end
  end

  assign bus.fetch_ready_o = ready;
  assign bus.count_o       = count;

  // Slots already consumed through the bypass are skipped; the rest pack from wr_ptr.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if ((CW'(k) >= skip_n) && (CW'(k) < push_n)) begin
        mem_instr[wr_ptr + PW'(k) - PW'(skip_n)] <= bus.fetch_instr_i[k*ISA_SIZE +: ISA_SIZE];
        mem_pc[wr_ptr + PW'(k) - PW'(skip_n)]    <= bus.fetch_pc_i + ADDR_SIZE'(4*k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + (bypass ? PW'(0) : PW'(pop_n));
      wr_ptr <= wr_ptr + PW'(push_n - skip_n);
      count  <= count + push_n - pop_n;
    end
  end

  count_bound: assert property (@(posedge clk_i) disable iff (!rstn_i) count <= CW'(DEPTH));

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed vector table, hand sequences and
// random traffic against a queue-based reference model (honours IQUEUE_BYPASS_EN).
module tb_instr_queue;
  localparam int DEPTH = 4;
  localparam int FW    = 2;
  localparam int IW    = 1;
  localparam int ISA   = 32;
  localparam int ADDR  = 64;
  localparam int FCW   = $clog2(FW+1);
  localparam int TCW   = $clog2(IW+1);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  instr_queue_if #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW),
                   .ISA_SIZE(ISA), .ADDR_SIZE(ADDR)) iq_if ();

  instr_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW),
                .ISA_SIZE(ISA), .ADDR_SIZE(ADDR)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (iq_if)
  );

  typedef struct {
    logic [ISA-1:0]  instr;
    logic [ADDR-1:0] pc;
  } entry_t;

  typedef struct {
    bit          f;
    bit          v;
    int          cnt;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [63:0] pc;
    int          take;
    int          e_count;
    bit          e_ready;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
  } vec_t;

  entry_t model_q[$];
  vec_t   vecs[19];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    iq_if.flush_i       = 1'b0;
    iq_if.fetch_valid_i = 1'b0;
    iq_if.fetch_cnt_i   = '0;
    iq_if.fetch_instr_i = '0;
    iq_if.fetch_pc_i    = '0;
    iq_if.issue_take_i  = '0;
  endtask

  // One clock of stimulus: outputs are compared with the model mid-cycle, then the model advances.
  task automatic applyStimulus(input bit f, input bit v, input int c,
                               input logic [FW*ISA-1:0] instr, input logic [ADDR-1:0] pc,
                               input int take);
    entry_t pushed[$];
    entry_t visible[$];
    bit     ready_exp;
    bit     bypassed;
    int     cm, tm, n_push, n_pop, lim;
    iq_if.flush_i       = f;
    iq_if.fetch_valid_i = v;
    iq_if.fetch_cnt_i   = FCW'(c);
    iq_if.fetch_instr_i = instr;
    iq_if.fetch_pc_i    = pc;
    iq_if.issue_take_i  = TCW'(take);
    cm = c & ((1 << FCW) - 1);
    tm = take & ((1 << TCW) - 1);
    @(negedge clk);
    ready_exp = (DEPTH - model_q.size()) >= FW;
    n_push = 0;
    if (v && ready_exp && !f) n_push = (cm > FW) ? FW : cm;
    for (int k = 0; k < n_push; k++) begin
      pushed.push_back('{instr[k*ISA +: ISA], pc + ADDR'(4*k)});
    end
    bypassed = 1'b0;
`ifdef IQUEUE_BYPASS_EN
    bypassed = (model_q.size() == 0) && (n_push > 0);
`endif
    visible = bypassed ? pushed : model_q;
    checkValue("cyc_count", 64'(iq_if.count_o), 64'(model_q.size()));
    checkValue("cyc_ready", 64'(iq_if.fetch_ready_o), 64'(ready_exp));
    for (int j = 0; j < IW; j++) begin
      checkValue($sformatf("cyc_valid%0d", j), 64'(iq_if.issue_valid_o[j]), 64'(j < visible.size()));
      if (j < visible.size()) begin
        checkValue($sformatf("cyc_instr%0d", j), 64'(iq_if.issue_instr_o[j*ISA +: ISA]), 64'(visible[j].instr));
        checkValue($sformatf("cyc_pc%0d", j), 64'(iq_if.issue_pc_o[j*ADDR +: ADDR]), 64'(visible[j].pc));
      end
    end
    if (f) begin
      model_q.delete();
    end else begin
      lim   = (visible.size() < IW) ? visible.size() : IW;
      n_pop = (tm < lim) ? tm : lim;
      if (bypassed) model_q = pushed;
      repeat (n_pop) void'(model_q.pop_front());
      if (!bypassed) begin
        foreach (pushed[k]) model_q.push_back(pushed[k]);
      end
    end
    @(posedge clk);
    #1;
    driveIdle();
  endtask

  task automatic checkOutput(input string name, input int e_count, input bit e_ready,
                             input bit e_valid, input logic [31:0] e_instr, input logic [63:0] e_pc);
    #1;
    checkValue({name, "_count"}, 64'(iq_if.count_o), 64'(e_count));
    checkValue({name, "_ready"}, 64'(iq_if.fetch_ready_o), 64'(e_ready));
    checkValue({name, "_valid"}, 64'(iq_if.issue_valid_o[0]), 64'(e_valid));
    if (e_valid) begin
      checkValue({name, "_instr"}, 64'(iq_if.issue_instr_o[ISA-1:0]), 64'(e_instr));
      checkValue({name, "_pc"}, 64'(iq_if.issue_pc_o[ADDR-1:0]), e_pc);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //           f  v  cnt i0            i1            pc                     take cnt rdy vld instr          pc
    vecs[0]  = '{0, 1, 2, 32'h00000013, 32'h00100093, 64'h1000,              0,   2,  1,  1,  32'h00000013, 64'h1000};
    vecs[1]  = '{0, 1, 2, 32'h00200113, 32'h00300193, 64'h1008,              0,   4,  0,  1,  32'h00000013, 64'h1000};
    vecs[2]  = '{0, 1, 2, 32'hdeadbeef, 32'hcafef00d, 64'h3000,              0,   4,  0,  1,  32'h00000013, 64'h1000};
    vecs[3]  = '{0, 0, 0, 32'h0,        32'h0,        64'h0,                 1,   3,  0,  1,  32'h00100093, 64'h1004};
    vecs[4]  = '{0, 0, 0, 32'h0,        32'h0,        64'h0,                 1,   2,  1,  1,  32'h00200113, 64'h1008};
    vecs[5]  = '{0, 1, 2, 32'h00400213, 32'h00500293, 64'h2000,              0,   4,  0,  1,  32'h00200113, 64'h1008};
    vecs[6]  = '{0, 0, 0, 32'h0,        32'h0,        64'h0,                 1,   3,  0,  1,  32'h00300193, 64'h100c};
    vecs[7]  = '{0, 0, 0, 32'h0,        32'h0,        64'h0,                 1,   2,  1,  1,  32'h00400213, 64'h2000};
    vecs[8]  = '{0, 0, 0, 32'h0,        32'h0,        64'h0,                 1,   1,  1,  1,  32'h00500293, 64'h2004};
    vecs[9]  = '{0, 1, 1, 32'h00600313, 32'h00700393, 64'hffff_ffff_ffff_fffc, 1, 1,  1,  1,  32'h00600313, 64'hffff_ffff_ffff_fffc};
    vecs[10] = '{0, 1, 2, 32'h00800413, 32'h00900493, 64'hffff_ffff_ffff_fffc, 1, 2,  1,  1,  32'h00800413, 64'hffff_ffff_ffff_fffc};
    vecs[11] = '{0, 0, 0, 32'h0,        32'h0,        64'h0,                 1,   1,  1,  1,  32'h00900493, 64'h0};
    vecs[12] = '{0, 1, 3, 32'h00a00513, 32'h00b00593, 64'h4000,              0,   3,  0,  1,  32'h00900493, 64'h0};
    vecs[13] = '{1, 1, 2, 32'h11111111, 32'h22222222, 64'h5555,              1,   0,  1,  0,  32'h0,        64'h0};
    vecs[14] = '{0, 0, 0, 32'h0,        32'h0,        64'h0,                 1,   0,  1,  0,  32'h0,        64'h0};
    vecs[15] = '{0, 1, 0, 32'h33333333, 32'h44444444, 64'h6666,              0,   0,  1,  0,  32'h0,        64'h0};
    vecs[16] = '{0, 1, 2, 32'h00c00613, 32'h00d00693, 64'h5000,              0,   2,  1,  1,  32'h00c00613, 64'h5000};
    vecs[17] = '{1, 1, 2, 32'h00e00713, 32'h00f00793, 64'h6000,              1,   0,  1,  0,  32'h0,        64'h0};
    vecs[18] = '{0, 1, 1, 32'h01000713, 32'h0,        64'h7000,              0,   1,  1,  1,  32'h01000713, 64'h7000};

    driveIdle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset", 0, 1, 0, 32'h0, 64'h0);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].f, vecs[i].v, vecs[i].cnt, {vecs[i].i1, vecs[i].i0}, vecs[i].pc, vecs[i].take);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_ready, vecs[i].e_valid,
                  vecs[i].e_instr, vecs[i].e_pc);
    end

    // Asynchronous reset in the middle of a cycle with three entries held.
    applyStimulus(0, 1, 2, {32'h01200813, 32'h01100793}, 64'h9000, 0);
    checkOutput("pre_reset", 3, 0, 1, 32'h01000713, 64'h7000);
    #2;
    rstn = 1'b0;
    checkOutput("reset_async", 0, 1, 0, 32'h0, 64'h0);
    model_q.delete();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 0, 1, 0, 32'h0, 64'h0);

    // Push into an empty queue while decode takes one slot.
    applyStimulus(0, 1, 1, {32'h0, 32'h01300893}, 64'h8000, 1);
`ifdef IQUEUE_BYPASS_EN
    checkOutput("empty_push_take", 0, 1, 0, 32'h0, 64'h0);
`else
    checkOutput("empty_push_take", 1, 1, 1, 32'h01300893, 64'h8000);
`endif
    applyStimulus(0, 0, 0, '0, '0, 1);
    checkOutput("drain", 0, 1, 0, 32'h0, 64'h0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                    int'($urandom_range(0, (1 << FCW) - 1)),
                    {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    int'($urandom_range(0, (1 << TCW) - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
Parametrised instruction queue between the fetch stage (IF) and decode. Each cycle it accepts 1..FETCH_WIDTH instructions from a fetched cache line and presents up to ISSUE_WIDTH oldest instructions, with their PCs, to decode in program order. It generalises the fixed 4-entry, single-issue queue to any power-of-two depth, multi-instruction push, multi-instruction pop, and pipeline flush.

Parameters:
DEPTH, 4, number of entries; power of two, must be >= FETCH_WIDTH and >= ISSUE_WIDTH
FETCH_WIDTH, 2, instructions per fetch packet (ICACHE_LINE_SIZE/ISA_SIZE)
ISSUE_WIDTH, 1, instruction slots presented to decode
ISA_SIZE, 32, instruction width in bits
ADDR_SIZE, 64, PC width in bits

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
flush_i  in  1  discard all entries (redirect/exception)
fetch_valid_i  in  1  fetch packet valid
fetch_ready_o  out  1  queue can accept a full packet
fetch_cnt_i  in  $clog2(FETCH_WIDTH+1)  valid instructions in packet, slots 0..cnt-1
fetch_instr_i  in  FETCH_WIDTH*ISA_SIZE  packet; slot k at bits [k*ISA_SIZE +: ISA_SIZE]
fetch_pc_i  in  ADDR_SIZE  PC of slot 0; slot k PC = fetch_pc_i + 4k (modulo 2^ADDR_SIZE)
issue_valid_o  out  ISSUE_WIDTH  slot j valid; always a contiguous prefix
issue_instr_o  out  ISSUE_WIDTH*ISA_SIZE  oldest instructions, slot 0 = oldest
issue_pc_o  out  ISSUE_WIDTH*ADDR_SIZE  matching PCs
issue_take_i  in  $clog2(ISSUE_WIDTH+1)  number of slots consumed this cycle, taken as a prefix
count_o  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: circular buffer of DEPTH entries {instr, pc}; rd_ptr, wr_ptr (log2 DEPTH bits, natural wrap); count register 0..DEPTH.
- Reset (rstn_i low, asynchronous): rd_ptr=wr_ptr=0, count=0; issue_valid_o=0, count_o=0, fetch_ready_o=1. Entry contents are not reset.
- fetch_ready_o = (DEPTH - count) >= FETCH_WIDTH, computed from the registered count only. A pop in the same cycle does not raise ready.
- Push: accepted when fetch_valid_i && fetch_ready_o && !flush_i. Writes fetch_cnt_i entries at wr_ptr..wr_ptr+cnt-1 (wrapping); wr_ptr += cnt. cnt=0 is a no-op. cnt > FETCH_WIDTH is clamped to FETCH_WIDTH.
- Issue outputs are combinational from storage: slot j valid iff j < count; data comes from entry rd_ptr+j (wrapping). Latency push to issue is 1 cycle.
- Pop: effective pop = min(issue_take_i, number of valid slots); rd_ptr += pop. Over-take is clamped with no underflow.
- Simultaneous push and pop: count_next = count + push - pop, in one cycle.
- Flush: synchronous and dominant. rd_ptr=wr_ptr=0 and count=0 next cycle; same-cycle push and pop are ignored. The issue outputs still show the pre-flush state in the flush cycle; decode must gate them with flush_i.
- Ordering: strict program order across wrap-around.
- Assertion: count never exceeds DEPTH.

Optional Feature:
IQUEUE_BYPASS_EN.
- Defined: when count==0 and a push is accepted, the pushed slots drive the issue outputs combinationally in the same cycle (0-cycle latency).
- Slots taken by issue_take_i in that cycle are not written; only the remainder is stored and counted.
- fetch_ready_o is unchanged. Flush still blocks both bypass and write.
- Undefined: 1-cycle latency as above, and there is no combinational path from fetch inputs to issue outputs.

Test Plan:
- Reset: rstn_i low mid-traffic, with count=3 -> immediately issue_valid_o=0, count_o=0, fetch_ready_o=1. After release the queue is empty.
- Push {0x00000013, 0x00100093}, pc 0x1000, cnt 2 -> next cycle issue_instr=0x00000013, pc=0x1000, count_o=2. Take 1 -> next cycle instr 0x00100093, pc 0x1004.
- Fill, DEPTH=4: two cnt=2 pushes -> count_o=4, fetch_ready_o=0. A held third push is not accepted and count stays 4.
- Wrap: from count 4, take 1 -> count 3, ready stays 0. Take 1 -> count 2, ready 1. Push pc 0x2000 cnt 2 -> issue order preserved: remaining old entries, then 0x2000, then 0x2004.
- Flush: flush_i with fetch_valid_i=1 and issue_take_i=1 at count 3 -> next cycle count_o=0, issue_valid_o=0, no entry written.
- Partial and edge cases: push cnt 1 with pc 0xFFFF_FFFF_FFFF_FFFC -> only slot 0 stored, count +1. With cnt 2, slot 1 PC wraps to 0x0. With IQUEUE_BYPASS_EN, an empty-queue push with take 1 -> the instruction is issued in the same cycle.
